// File: rtl/writeback_unit.sv
// writeback_unit
//   Write-side master of the register file. ALU results and load results share
//   the single write port (reg_write / wr_rd / wr_data). ALU results always win.
//   Loads that cannot go straight through are buffered in a small load queue.
//   The queue drains in cycles where the ALU does not use the port.
//   Outputs are registered on posedge clk, so they are stable when the register
//   file writes on negedge.
//
// Optional feature: define WB_BYPASS_EN to add a combinational operand bypass.
//   The bypass searches the registered write port and the load queue.
//
// Parameters
//   LQ_DEPTH        load-queue entries (power of 2, >= 2)
//   STARVE_MAX      cycles the queue head may wait before alu_hold is raised
//   INSTR_REG_SIZE  register index width (core value 5)
//   WD_SIZE         data width (core value 32)
//
// Ports
//   clk, reset_n               clock; synchronous active-low reset
//   alu_valid/alu_rd/alu_data  ALU result (cannot be back-pressured)
//   mem_valid/mem_ready        load handshake; mem_ready is combinational
//   mem_rd/mem_data            load result
//   reg_write/wr_rd/wr_data    register-file write port (registered)
//   lq_count                   load-queue occupancy
//   alu_hold                   asks upstream not to issue an ALU op next cycle
//   byp_rs*/byp_rs*_hit/_data  bypass lookup (WB_BYPASS_EN only)

module writeback_unit #(
  parameter int LQ_DEPTH       = 4,
  parameter int STARVE_MAX     = 8,
  parameter int INSTR_REG_SIZE = 5,
  parameter int WD_SIZE        = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [INSTR_REG_SIZE-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [INSTR_REG_SIZE-1:0] mem_rd,
  input  logic [WD_SIZE-1:0]        mem_data,
  output logic                      reg_write,
  output logic [INSTR_REG_SIZE-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data,
  output logic [$clog2(LQ_DEPTH):0] lq_count,
`ifdef WB_BYPASS_EN
  input  logic [INSTR_REG_SIZE-1:0] byp_rs1,
  input  logic [INSTR_REG_SIZE-1:0] byp_rs2,
  output logic                      byp_rs1_hit,
  output logic                      byp_rs2_hit,
  output logic [WD_SIZE-1:0]        byp_rs1_data,
  output logic [WD_SIZE-1:0]        byp_rs2_data,
`endif
  output logic                      alu_hold
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [INSTR_REG_SIZE-1:0] lq_rd   [LQ_DEPTH];
  logic [WD_SIZE-1:0]        lq_data [LQ_DEPTH];
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [SW-1:0]             starve_cnt;
  logic [SW-1:0]             starve_nxt;

  logic alu_win;
  logic lq_empty;
  logic mem_accept;
  logic load_live;
  logic pop;
  logic cut;
  logic push;

  assign mem_ready  = reset_n && (lq_count < CW'(LQ_DEPTH));
  assign mem_accept = mem_valid && mem_ready;
  // x0 results are discarded, so they never claim the port or a queue slot.
  assign alu_win    = alu_valid && (alu_rd != '0);
  assign load_live  = mem_accept && (mem_rd != '0);
  assign lq_empty   = (lq_count == '0);
  assign pop        = !alu_win && !lq_empty;
  // A load may skip the queue only when nothing older is waiting in it.
  assign cut        = !alu_win && lq_empty && load_live;
  assign push       = load_live && !cut;

  always_comb begin
    starve_nxt = starve_cnt;
    if (lq_empty || pop)
      starve_nxt = '0;
    else if (starve_cnt < SW'(STARVE_MAX))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      lq_count   <= '0;
      starve_cnt <= '0;
      alu_hold   <= 1'b0;
      reg_write  <= 1'b0;
      wr_rd      <= '0;
      wr_data    <= '0;
    end else begin
      if (alu_win) begin
        reg_write <= 1'b1;
        wr_rd     <= alu_rd;
        wr_data   <= alu_data;
      end else if (pop) begin
        reg_write <= 1'b1;
        wr_rd     <= lq_rd[head];
        wr_data   <= lq_data[head];
      end else if (cut) begin
        reg_write <= 1'b1;
        wr_rd     <= mem_rd;
        wr_data   <= mem_data;
      end else begin
        // Address and data keep their last values when the port is idle.
        reg_write <= 1'b0;
      end

      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);

      case ({push, pop})
        2'b10:   lq_count <= lq_count + CW'(1);
        2'b01:   lq_count <= lq_count - CW'(1);
        default: lq_count <= lq_count;
      endcase

      starve_cnt <= starve_nxt;
      alu_hold   <= (starve_nxt == SW'(STARVE_MAX));
    end
  end

  // Queue storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      lq_rd[tail]   <= mem_rd;
      lq_data[tail] <= mem_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Returns {hit, data}. Entries are visited oldest to newest so that later
  // matches overwrite earlier ones. The registered write port is newest of all.
  function automatic logic [WD_SIZE:0] byp_search(input logic [INSTR_REG_SIZE-1:0] rs);
    logic [PW-1:0]      idx;
    logic               hit;
    logic [WD_SIZE-1:0] data;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (rs != '0) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < lq_count) && (lq_rd[idx] == rs)) begin
          hit  = 1'b1;
          data = lq_data[idx];
        end
      end
      if (reg_write && (wr_rd == rs)) begin
        hit  = 1'b1;
        data = wr_data;
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {byp_rs1_hit, byp_rs1_data} = byp_search(byp_rs1);
    {byp_rs2_hit, byp_rs2_data} = byp_search(byp_rs2);
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [2:0]  lq_count;
  logic        alu_hold;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1;
  logic [4:0]  byp_rs2;
  logic        byp_rs1_hit;
  logic        byp_rs2_hit;
  logic [31:0] byp_rs1_data;
  logic [31:0] byp_rs2_data;
`endif

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .reg_write (reg_write),
    .wr_rd     (wr_rd),
    .wr_data   (wr_data),
    .lq_count  (lq_count),
`ifdef WB_BYPASS_EN
    .byp_rs1      (byp_rs1),
    .byp_rs2      (byp_rs2),
    .byp_rs1_hit  (byp_rs1_hit),
    .byp_rs2_hit  (byp_rs2_hit),
    .byp_rs1_data (byp_rs1_data),
    .byp_rs2_data (byp_rs2_data),
`endif
    .alu_hold  (alu_hold)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write the DUT presents must match the queue head.
  task automatic monitor_loop();
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (reg_write === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", wr_rd, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_rd, wr_data} !== e) begin
            bad++;
            $display("FAIL write_port: got rd=%0d data=%h, expected rd=%0d data=%h",
                     wr_rd, wr_data, e[36:32], e[31:0]);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    reset_n = 1'b0;
    idle();
`ifdef WB_BYPASS_EN
    byp_rs1 = 5'd0;
    byp_rs2 = 5'd0;
`endif

    // Reset state
    step();
    step();
    chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
    chk("rst_wr_rd",     {27'b0, wr_rd},     32'd0);
    chk("rst_wr_data",   wr_data,            32'd0);
    chk("rst_lq_count",  {29'b0, lq_count},  32'd0);
    chk("rst_alu_hold",  {31'b0, alu_hold},  32'd0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_mem_ready", {31'b0, mem_ready}, 32'd1);

    // ALU-only write, then idle holds address/data
    expect_wr(5'd5, 32'hDEADBEEF);
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    step();
    idle();
    chk("alu_reg_write", {31'b0, reg_write}, 32'd1);
    chk("alu_wr_rd",     {27'b0, wr_rd},     32'd5);
    chk("alu_wr_data",   wr_data,            32'hDEADBEEF);
    step();
    chk("idle_reg_write", {31'b0, reg_write}, 32'd0);
    chk("idle_wr_rd",     {27'b0, wr_rd},     32'd5);
    chk("idle_wr_data",   wr_data,            32'hDEADBEEF);

    // Cut-through load
    expect_wr(5'd7, 32'h1234);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    chk("ct_mem_ready", {31'b0, mem_ready}, 32'd1);
    step();
    idle();
    chk("ct_lq_count", {29'b0, lq_count}, 32'd0);
    chk("ct_wr_rd",    {27'b0, wr_rd},    32'd7);
    step();

    // x0 filtering
    set_in(1'b1, 5'd0, 32'h999, 1'b1, 5'd0, 32'h777);
    chk("x0_mem_ready", {31'b0, mem_ready}, 32'd1);
    step();
    idle();
    chk("x0_lq_count",  {29'b0, lq_count},  32'd0);
    chk("x0_reg_write", {31'b0, reg_write}, 32'd0);
    expect_wr(5'd8, 32'h88);
    set_in(1'b1, 5'd0, 32'h999, 1'b1, 5'd8, 32'h88);
    step();
    idle();
    chk("x0_alu_slot_cnt", {29'b0, lq_count}, 32'd0);
    expect_wr(5'd6, 32'h66);
    set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'h777);
    step();
    idle();
    chk("x0_load_cnt", {29'b0, lq_count}, 32'd0);
    step();
    step();
    chk("x0_sb_empty", exp_q.size(), 32'd0);

    // Full queue: ALU busy, 5 loads offered, 4 accepted, then drain in order
    for (int i = 0; i < 5; i++) expect_wr(5'(10 + i), 32'h100 + i);
    for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 32'h200 + i);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(20 + i), 32'h200 + i);
      chk("fq_count", {29'b0, lq_count}, i);
      chk("fq_ready", {31'b0, mem_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    chk("fq_full_count", {29'b0, lq_count},  32'd4);
    chk("fq_full_ready", {31'b0, mem_ready}, 32'd0);
    step();
    chk("fq_pop1_count", {29'b0, lq_count},  32'd3);
    chk("fq_pop1_ready", {31'b0, mem_ready}, 32'd1);
    step();
    step();
    step();
    chk("fq_drained", {29'b0, lq_count}, 32'd0);
    step();
    step();
    chk("fq_sb_empty", exp_q.size(), 32'd0);

    // Starvation: ALU busy with one load queued
    for (int j = 0; j < 11; j++) expect_wr(5'd3, 32'h300 + j);
    expect_wr(5'd4, 32'h400);
    for (int j = 0; j < 11; j++) begin
      set_in(1'b1, 5'd3, 32'h300 + j, (j == 0), 5'd4, 32'h400);
      chk("starve_hold", {31'b0, alu_hold}, (j >= 9) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    chk("starve_sat_hold", {31'b0, alu_hold}, 32'd1);
    chk("starve_count",    {29'b0, lq_count}, 32'd1);
    step();
    chk("starve_release", {31'b0, alu_hold}, 32'd0);
    chk("starve_popped",  {29'b0, lq_count}, 32'd0);
    step();
    step();
    chk("starve_sb_empty", exp_q.size(), 32'd0);

`ifdef WB_BYPASS_EN
    // Bypass: queued load x9 and registered write x2
    expect_wr(5'd2, 32'h22);
    expect_wr(5'd9, 32'h55);
    set_in(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h55);
    step();
    idle();
    byp_rs1 = 5'd9;
    byp_rs2 = 5'd2;
    #1;
    chk("byp_rs1_hit",  {31'b0, byp_rs1_hit}, 32'd1);
    chk("byp_rs1_data", byp_rs1_data,         32'h55);
    chk("byp_rs2_hit",  {31'b0, byp_rs2_hit}, 32'd1);
    chk("byp_rs2_data", byp_rs2_data,         32'h22);
    byp_rs2 = 5'd0;
    #1;
    chk("byp_x0_hit", {31'b0, byp_rs2_hit}, 32'd0);
    step();
    step();
    byp_rs1 = 5'd0;
    chk("byp_sb_empty", exp_q.size(), 32'd0);
`endif

    // Reset mid-operation with 3 loads queued
    for (int k = 0; k < 3; k++) expect_wr(5'd1, 32'hA0 + k);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 5'd1, 32'hA0 + k, 1'b1, 5'(11 + k), 32'hB0 + k);
      step();
    end
    idle();
    chk("mid_count_before", {29'b0, lq_count}, 32'd3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_count_after", {29'b0, lq_count},  32'd0);
    chk("mid_reg_write",   {31'b0, reg_write}, 32'd0);
    for (int k = 0; k < 6; k++) step();
    chk("mid_still_empty", {29'b0, lq_count}, 32'd0);
    chk("mid_sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
